rev_undo_engine: RTL and testbench

Sequential companion to the combinational multi-target Toffoli gate cells. It holds a WIDTH-bit reversible register, applies gates of the form "flip all target bits when all control bits are 1" in the forward direction, and records each applied gate on a LIFO history. It runs the same history in the other direction to uncompute: each gate is self-inverse, so popping an entry and re-applying it restores the prior value. It sits between the instruction sequencer and the reversible datapath and provides single-step undo and full rewind to the last load point.

---
 rtl/rev_undo_engine_if.sv | 32 +++
 rtl/rev_undo_engine.sv | 199 +++++++++++++++++++
 tb/tb_rev_undo_engine.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/rev_undo_engine_if.sv
`default_nettype none
// ============================================================================
//  Module      : rev_undo_engine_if
//  Description : Command channel between the instruction sequencer (master)
//                and the reversible undo engine (slave). Carries a
//                valid/ready handshake, the opcode, both gate masks and the
//                load value.
//  Revision    : 1.0 - initial release
// ============================================================================
interface rev_undo_engine_if #(
    parameter int WIDTH = 5
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [WIDTH-1:0] cmd_ctrl;
    logic [WIDTH-1:0] cmd_tgt;
    logic [WIDTH-1:0] cmd_data;

    // Sequencer side: offers commands and watches ready.
    modport master (
        output cmd_valid, cmd_op, cmd_ctrl, cmd_tgt, cmd_data,
        input  cmd_ready
    );

    // Engine side: consumes commands and drives ready.
    modport slave (
        input  cmd_valid, cmd_op, cmd_ctrl, cmd_tgt, cmd_data,
        output cmd_ready
    );
endinterface
`default_nettype wire

// File: rtl/rev_undo_engine.sv
`default_nettype none
// ============================================================================
//  Module      : rev_undo_engine
//  Description : WIDTH-bit reversible register driven by multi-target Toffoli
//                gates (flip tgt when all ctrl bits are 1). Every applied
//                gate is pushed on a LIFO history so that UNDO (single step)
//                and REWIND (back to the last LOAD) can uncompute it by
//                re-applying the self-inverse gate.
//                Optional feature macro: REV_REWIND_CHECK_EN - keeps a
//                checkpoint of the last LOAD value and flags err instead of
//                done when a completed REWIND does not land on it.
//  Revision    : 1.0 - initial release
// ============================================================================
module rev_undo_engine #(
    parameter int WIDTH = 5,
    parameter int DEPTH = 16
) (
    input  wire logic                       clk,
    input  wire logic                       rst,
    rev_undo_engine_if.slave                cmd,
    output logic [WIDTH-1:0]                state_out,
    output logic [$clog2(DEPTH+1)-1:0]      depth_out,
    output logic                            busy,
    output logic                            done,
    output logic                            err
);

    localparam int c_DW = $clog2(DEPTH + 1);
    localparam int c_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_EW = 2 * WIDTH;

    localparam logic [1:0]      c_OP_LOAD   = 2'b00;
    localparam logic [1:0]      c_OP_APPLY  = 2'b01;
    localparam logic [1:0]      c_OP_UNDO   = 2'b10;
    localparam logic [c_DW-1:0] c_FULL      = c_DW'(DEPTH);
    localparam logic [c_DW-1:0] c_ONE       = c_DW'(1);

    typedef enum logic [0:0] {
        S_IDLE   = 1'b0,
        S_REWIND = 1'b1
    } fsm_t;

    fsm_t               r_fsm_q,   w_fsm_d;
    logic [WIDTH-1:0]   r_state_q, w_state_d;
    logic [c_DW-1:0]    r_depth_q, w_depth_d;
    logic               r_done_q,  w_done_d;
    logic               r_err_q,   w_err_d;
`ifdef REV_REWIND_CHECK_EN
    logic [WIDTH-1:0]   r_ckpt_q,  w_ckpt_d;
`endif

    // History storage: entry = {ctrl, tgt}; contents are don't-care at reset.
    logic [c_EW-1:0]    r_hist [DEPTH];
    logic               w_push;
    logic [c_AW-1:0]    w_push_idx;
    logic [c_AW-1:0]    w_top_idx;
    logic [c_EW-1:0]    w_top;
    logic [WIDTH-1:0]   w_pop_state;
    logic [WIDTH-1:0]   w_apply_state;

    // Gate fires when every control bit is set; ctrl == 0 always fires.
    function automatic logic [WIDTH-1:0] f_gate(
        input logic [WIDTH-1:0] s,
        input logic [WIDTH-1:0] c,
        input logic [WIDTH-1:0] t
    );
        return ((s & c) == c) ? (s ^ t) : s;
    endfunction

    // Top-of-stack lookup and the two candidate next states.
    always_comb begin
        w_push_idx    = c_AW'(r_depth_q);
        w_top_idx     = (r_depth_q == '0) ? '0 : c_AW'(r_depth_q - c_ONE);
        w_top         = r_hist[w_top_idx];
        w_pop_state   = f_gate(r_state_q, w_top[c_EW-1:WIDTH], w_top[WIDTH-1:0]);
        w_apply_state = f_gate(r_state_q, cmd.cmd_ctrl, cmd.cmd_tgt);
    end

    // Command decode and rewind sequencing; rejections leave everything as is.
    always_comb begin
        w_fsm_d   = r_fsm_q;
        w_state_d = r_state_q;
        w_depth_d = r_depth_q;
        w_done_d  = 1'b0;
        w_err_d   = 1'b0;
        w_push    = 1'b0;
`ifdef REV_REWIND_CHECK_EN
        w_ckpt_d  = r_ckpt_q;
`endif
        case (r_fsm_q)
            S_IDLE: begin
                if (cmd.cmd_valid) begin
                    case (cmd.cmd_op)
                        c_OP_LOAD: begin
                            w_state_d = cmd.cmd_data;
                            w_depth_d = '0;
                            w_done_d  = 1'b1;
`ifdef REV_REWIND_CHECK_EN
                            w_ckpt_d  = cmd.cmd_data;
`endif
                        end
                        c_OP_APPLY: begin
                            // Overlapping ctrl/tgt would not be self-inverse.
                            if (((cmd.cmd_ctrl & cmd.cmd_tgt) != '0) || (r_depth_q == c_FULL)) begin
                                w_err_d = 1'b1;
                            end else begin
                                w_state_d = w_apply_state;
                                w_depth_d = r_depth_q + c_ONE;
                                w_push    = 1'b1;
                                w_done_d  = 1'b1;
                            end
                        end
                        c_OP_UNDO: begin
                            if (r_depth_q == '0) begin
                                w_err_d = 1'b1;
                            end else begin
                                w_state_d = w_pop_state;
                                w_depth_d = r_depth_q - c_ONE;
                                w_done_d  = 1'b1;
                            end
                        end
                        default: begin
                            // Empty history: nothing to unwind, finish at once.
                            if (r_depth_q == '0) begin
                                w_done_d = 1'b1;
                            end else begin
                                w_fsm_d  = S_REWIND;
                            end
                        end
                    endcase
                end
            end
            S_REWIND: begin
                if (r_depth_q == '0) begin
                    w_fsm_d  = S_IDLE;
                    w_done_d = 1'b1;
                end else begin
                    w_state_d = w_pop_state;
                    w_depth_d = r_depth_q - c_ONE;
                    if (r_depth_q == c_ONE) begin
                        w_fsm_d = S_IDLE;
`ifdef REV_REWIND_CHECK_EN
                        // Landing off the checkpoint means the history was corrupted.
                        if (w_pop_state != r_ckpt_q) begin
                            w_err_d  = 1'b1;
                        end else begin
                            w_done_d = 1'b1;
                        end
`else
                        w_done_d = 1'b1;
`endif
                    end
                end
            end
            default: begin
                w_fsm_d = S_IDLE;
            end
        endcase
    end

    // Engine state registers; reset aborts any rewind in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fsm_q   <= S_IDLE;
            r_state_q <= '0;
            r_depth_q <= '0;
            r_done_q  <= 1'b0;
            r_err_q   <= 1'b0;
`ifdef REV_REWIND_CHECK_EN
            r_ckpt_q  <= '0;
`endif
        end else begin
            r_fsm_q   <= w_fsm_d;
            r_state_q <= w_state_d;
            r_depth_q <= w_depth_d;
            r_done_q  <= w_done_d;
            r_err_q   <= w_err_d;
`ifdef REV_REWIND_CHECK_EN
            r_ckpt_q  <= w_ckpt_d;
`endif
        end
    end

    // History write port.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_hist[w_push_idx] <= {cmd.cmd_ctrl, cmd.cmd_tgt};
        end
    end

    assign cmd.cmd_ready = (r_fsm_q == S_IDLE);
    assign busy          = (r_fsm_q == S_REWIND);
    assign state_out     = r_state_q;
    assign depth_out     = r_depth_q;
    assign done          = r_done_q;
    assign err           = r_err_q;

endmodule
`default_nettype wire

// File: tb/tb_rev_undo_engine.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rev_undo_engine
//  Description : Self-checking bench for rev_undo_engine. A behavioural model
//                (register value plus a history queue) predicts every cycle's
//                outputs into a scoreboard, which is popped after each edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rev_undo_engine;

    localparam int WIDTH = 5;
    localparam int DEPTH = 16;
    localparam int DW    = $clog2(DEPTH + 1);

    localparam logic [1:0] c_LOAD   = 2'b00;
    localparam logic [1:0] c_APPLY  = 2'b01;
    localparam logic [1:0] c_UNDO   = 2'b10;
    localparam logic [1:0] c_REWIND = 2'b11;

    logic             clk = 1'b0;
    logic             rst;
    logic [WIDTH-1:0] state_out;
    logic [DW-1:0]    depth_out;
    logic             busy;
    logic             done;
    logic             err;

    rev_undo_engine_if #(.WIDTH(WIDTH)) cmd_if ();

    rev_undo_engine #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd       (cmd_if),
        .state_out (state_out),
        .depth_out (depth_out),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] st;
        int               dp;
        logic             dn;
        logic             er;
        logic             bz;
    } exp_t;

    exp_t                 sb[$];
    int                   n_checks = 0;
    int                   n_errors = 0;
    logic [WIDTH-1:0]     m_state;
    logic [2*WIDTH-1:0]   m_hist[$];

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Model gate: walk the control bits one by one.
    function automatic logic [WIDTH-1:0] m_gate(input logic [WIDTH-1:0] s,
                                                input logic [WIDTH-1:0] c,
                                                input logic [WIDTH-1:0] t);
        logic fire;
        fire = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            if (c[i] && !s[i]) fire = 1'b0;
        end
        return fire ? (s ^ t) : s;
    endfunction

    task automatic expect_now(input logic dn, input logic er, input logic bz);
        exp_t e;
        e.st = m_state;
        e.dp = m_hist.size();
        e.dn = dn;
        e.er = er;
        e.bz = bz;
        sb.push_back(e);
    endtask

    task automatic compare_next(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            n_errors++;
            $display("FAIL %s: scoreboard empty", tag);
            return;
        end
        e = sb.pop_front();
        check_value({tag, ".state"}, 32'(state_out),        32'(e.st));
        check_value({tag, ".depth"}, 32'(depth_out),        32'(e.dp));
        check_value({tag, ".done"},  32'(done),             32'(e.dn));
        check_value({tag, ".err"},   32'(err),              32'(e.er));
        check_value({tag, ".busy"},  32'(busy),             32'(e.bz));
        check_value({tag, ".ready"}, 32'(cmd_if.cmd_ready), 32'(!e.bz));
    endtask

    // One single-cycle command: model it, drive it, compare after the edge.
    task automatic issue(input logic [1:0] op, input logic [WIDTH-1:0] ctrl,
                         input logic [WIDTH-1:0] tgt, input logic [WIDTH-1:0] data,
                         input string tag);
        logic [2*WIDTH-1:0] e;
        case (op)
            c_LOAD: begin
                m_state = data;
                m_hist.delete();
                expect_now(1'b1, 1'b0, 1'b0);
            end
            c_APPLY: begin
                if (((ctrl & tgt) != '0) || (m_hist.size() == DEPTH)) begin
                    expect_now(1'b0, 1'b1, 1'b0);
                end else begin
                    m_state = m_gate(m_state, ctrl, tgt);
                    m_hist.push_back({ctrl, tgt});
                    expect_now(1'b1, 1'b0, 1'b0);
                end
            end
            default: begin
                if (m_hist.size() == 0) begin
                    expect_now(1'b0, 1'b1, 1'b0);
                end else begin
                    e = m_hist.pop_back();
                    m_state = m_gate(m_state, e[2*WIDTH-1:WIDTH], e[WIDTH-1:0]);
                    expect_now(1'b1, 1'b0, 1'b0);
                end
            end
        endcase
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_op    = op;
        cmd_if.cmd_ctrl  = ctrl;
        cmd_if.cmd_tgt   = tgt;
        cmd_if.cmd_data  = data;
        @(posedge clk); #1;
        cmd_if.cmd_valid = 1'b0;
        compare_next(tag);
    endtask

    // REWIND; while busy a stray LOAD is held on the bus and must be ignored.
    // abort_after >= 0 asserts rst after that many pops.
    task automatic rewind(input string tag, input int abort_after);
        int                 n;
        logic [2*WIDTH-1:0] e;
        n = m_hist.size();
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_op    = c_REWIND;
        @(posedge clk); #1;
        if (n == 0) begin
            cmd_if.cmd_valid = 1'b0;
            expect_now(1'b1, 1'b0, 1'b0);
            compare_next({tag, ".empty"});
            return;
        end
        cmd_if.cmd_op   = c_LOAD;
        cmd_if.cmd_data = 5'h1A;
        expect_now(1'b0, 1'b0, 1'b1);
        compare_next({tag, ".accept"});
        for (int i = 0; i < n; i++) begin
            if (i == abort_after) begin
                #2 rst = 1'b1;
                #1;
                cmd_if.cmd_valid = 1'b0;
                m_state = '0;
                m_hist.delete();
                expect_now(1'b0, 1'b0, 1'b0);
                compare_next({tag, ".abort"});
                @(negedge clk) rst = 1'b0;
                @(posedge clk); #1;
                return;
            end
            e = m_hist.pop_back();
            m_state = m_gate(m_state, e[2*WIDTH-1:WIDTH], e[WIDTH-1:0]);
            expect_now(i == n - 1, 1'b0, i != n - 1);
            @(posedge clk); #1;
            if (i == n - 1) cmd_if.cmd_valid = 1'b0;
            compare_next($sformatf("%s.pop%0d", tag, i));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        logic [1:0]       op;
        logic [WIDTH-1:0] c, t;
        int               r;
        rst              = 1'b1;
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_op    = c_LOAD;
        cmd_if.cmd_ctrl  = '0;
        cmd_if.cmd_tgt   = '0;
        cmd_if.cmd_data  = '0;
        m_state          = '0;
        #7;
        expect_now(1'b0, 1'b0, 1'b0);
        compare_next("reset");
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;

        // Single APPLY and its undo.
        issue(c_LOAD,  5'b00000, 5'b00000, 5'b00011, "load3");
        issue(c_APPLY, 5'b00011, 5'b11100, 5'b00000, "apply1");
        issue(c_UNDO,  5'b00000, 5'b00000, 5'b00000, "undo1");
        // Rejections.
        issue(c_APPLY, 5'b00011, 5'b00110, 5'b00000, "overlap");
        issue(c_UNDO,  5'b00000, 5'b00000, 5'b00000, "undo_empty");

        // Fill the history, then overflow.
        issue(c_LOAD, 5'b00000, 5'b00000, 5'b00000, "load0");
        for (int i = 0; i < DEPTH; i++) begin
            issue(c_APPLY, 5'b00000, 5'b00001, 5'b00000, $sformatf("fill%0d", i));
        end
        issue(c_APPLY, 5'b00000, 5'b00001, 5'b00000, "overflow");

        // Three-gate rewind.
        issue(c_LOAD,  5'b00000, 5'b00000, 5'b00001, "load1");
        issue(c_APPLY, 5'b00001, 5'b00010, 5'b00000, "g1");
        issue(c_APPLY, 5'b00000, 5'b10000, 5'b00000, "g2");
        issue(c_APPLY, 5'b00011, 5'b01100, 5'b00000, "g3");
        rewind("rw3", -1);

        // Reset in the middle of a rewind.
        issue(c_LOAD,  5'b00000, 5'b00000, 5'b00001, "load1b");
        issue(c_APPLY, 5'b00001, 5'b00010, 5'b00000, "g1b");
        issue(c_APPLY, 5'b00000, 5'b10000, 5'b00000, "g2b");
        issue(c_APPLY, 5'b00011, 5'b01100, 5'b00000, "g3b");
        rewind("rwabort", 1);

        // Rewind with nothing recorded.
        rewind("rw0", -1);

        // Randomised mix, including gates that do not fire.
        issue(c_LOAD, 5'b00000, 5'b00000, 5'($urandom), "rload");
        for (int i = 0; i < 60; i++) begin
            r = $urandom_range(0, 11);
            c = 5'($urandom);
            t = 5'($urandom);
            if (r < 9) t = t & ~c;
            if (r == 0)      op = c_LOAD;
            else if (r < 8)  op = c_APPLY;
            else if (r < 11) op = c_UNDO;
            else             op = c_REWIND;
            if (op == c_REWIND) rewind($sformatf("rnd%0d", i), -1);
            else                issue(op, c, t, 5'($urandom), $sformatf("rnd%0d", i));
        end
        rewind("rwfinal", -1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
